// File: rtl/mem_arbiter.sv
// Two-port req/ack arbiter and sequencer in front of a single-port synchronous memory.
// Optional round-robin arbitration with `define MEM_ARB_RR_EN (default: port 0 has fixed priority).
module mem_arbiter #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
    output logic          MemWrite,
    output logic          MemRead,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          gnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_CAPT  = 2'd2;
    localparam logic [1:0] S_ACK   = 2'd3;

    logic [1:0] r_state;
    logic       r_we;
    logic       w_pick;

`ifdef MEM_ARB_RR_EN
    logic       r_rr;

    // The pointer only decides real collisions; a lone requester always wins.
    always_comb begin
        w_pick = 1'b0;
        if (req0 && req1) begin
            w_pick = r_rr;
        end else begin
            w_pick = !req0;
        end
    end
`else
    always_comb begin
        w_pick = !req0;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_we      <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            MemWrite  <= 1'b0;
            MemRead   <= 1'b0;
            busy      <= 1'b0;
            gnt       <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata0    <= '0;
            rdata1    <= '0;
`ifdef MEM_ARB_RR_EN
            r_rr      <= 1'b0;
`endif
        end else begin
            MemWrite <= 1'b0;
            MemRead  <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (req0 || req1) begin
                        // Strobes and address are loaded here so they appear during ISSUE.
                        gnt       <= w_pick;
                        r_we      <= w_pick ? we1 : we0;
                        mem_addr  <= w_pick ? addr1 : addr0;
                        mem_wdata <= w_pick ? wdata1 : wdata0;
                        MemWrite  <= w_pick ? we1 : we0;
                        MemRead   <= w_pick ? !we1 : !we0;
                        busy      <= 1'b1;
                        r_state   <= S_ISSUE;
`ifdef MEM_ARB_RR_EN
                        if (req0 && req1) begin
                            r_rr <= !w_pick;
                        end
`endif
                    end
                end
                S_ISSUE: begin
                    r_state <= r_we ? S_ACK : S_CAPT;
                end
                S_CAPT: begin
                    if (gnt) begin
                        rdata1 <= mem_rdata;
                    end else begin
                        rdata0 <= mem_rdata;
                    end
                    r_state <= S_ACK;
                end
                S_ACK: begin
                    if (gnt) begin
                        ack1 <= 1'b1;
                    end else begin
                        ack0 <= 1'b1;
                    end
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: a behavioural model predicts memory
// transactions and per-port ack timing/read data; independent monitors compare.
module tb_mem_arbiter;
    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1;
    logic [DW-1:0] rdata0, rdata1;
    logic          MemWrite, MemRead;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy, gnt;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .MemWrite(MemWrite), .MemRead(MemRead), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .gnt(gnt)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory behind the arbiter ----------------
    logic [DW-1:0] tb_mem [256];
    always @(posedge clk) begin
        if (MemWrite) tb_mem[mem_addr] <= mem_wdata;
        if (MemRead) mem_rdata <= tb_mem[mem_addr];
    end

    // ---------------- reference model state ----------------
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] last_rd [2];
    logic          rr_ptr;
    logic [47:0]   exp_q0[$];   // {ack edge, rdata}
    logic [47:0]   exp_q1[$];
    logic [25:0]   exp_mq[$];   // {port, we, addr, wdata}

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Serve one transaction in the model starting at IDLE sampling edge n.
    task automatic serve(input int p, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int unsigned n, output int unsigned ack_at);
        logic [DW-1:0] rd;
        exp_mq.push_back({p[0], we, a, d});
        if (we) begin
            ref_mem[a] = d;
            rd = last_rd[p];
            ack_at = n + 2;
        end else begin
            rd = ref_mem[a];
            last_rd[p] = rd;
            ack_at = n + 3;
        end
        if (p == 0) exp_q0.push_back({ack_at, rd});
        else exp_q1.push_back({ack_at, rd});
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        logic [25:0] m;
        logic [47:0] e;
        if (!reset) begin
            assert (!(MemRead && MemWrite)) else begin
                errors++;
                $display("FAIL strobe_exclusive: MemRead=%0b MemWrite=%0b", MemRead, MemWrite);
            end
            if (MemRead || MemWrite) begin
                if (exp_mq.size() == 0) begin
                    check("strobe_unexpected", 64'({MemWrite, MemRead}), 64'd0);
                end else begin
                    m = exp_mq.pop_front();
                    check("mem_txn", 64'({gnt, MemWrite, MemRead, mem_addr, mem_wdata}),
                          64'({m[25], m[24], ~m[24], m[23:0]}));
                end
            end
            if (ack0) begin
                if (exp_q0.size() == 0) begin
                    check("ack0_unexpected", 64'(ack0), 64'd0);
                end else begin
                    e = exp_q0.pop_front();
                    check("ack0_cycle", 64'(cyc), 64'(e[47:16]));
                    check("rdata0", 64'(rdata0), 64'(e[15:0]));
                end
            end
            if (ack1) begin
                if (exp_q1.size() == 0) begin
                    check("ack1_unexpected", 64'(ack1), 64'd0);
                end else begin
                    e = exp_q1.pop_front();
                    check("ack1_cycle", 64'(cyc), 64'(e[47:16]));
                    check("rdata1", 64'(rdata1), 64'(e[15:0]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_txn(input logic u0, input logic u1, input logic w0, input logic w1,
                           input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        int first;
        int unsigned t, k, k2;
        logic done0, done1;
        t = cyc;
        if (u0 && u1) begin
`ifdef MEM_ARB_RR_EN
            first = rr_ptr ? 1 : 0;
            rr_ptr = (first == 0);
`else
            first = 0;
`endif
        end else begin
            first = u0 ? 0 : 1;
        end
        if (first == 0) begin
            serve(0, w0, a0, d0, t + 1, k);
            if (u1) serve(1, w1, a1, d1, k + 1, k2);
        end else begin
            serve(1, w1, a1, d1, t + 1, k);
            if (u0) serve(0, w0, a0, d0, k + 1, k2);
        end
        req0 = u0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = u1; we1 = w1; addr1 = a1; wdata1 = d1;
        done0 = !u0;
        done1 = !u1;
        for (int i = 0; i < 40 && !(done0 && done1); i++) begin
            @(posedge clk); #1;
            if (ack0) begin req0 = 1'b0; done0 = 1'b1; end
            if (ack1) begin req1 = 1'b0; done1 = 1'b1; end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        check("txn_done", 64'({done0, done1}), 64'd3);
    endtask

    task automatic hold_reads(input logic [AW-1:0] a, input int n_reads);
        int unsigned k;
        int seen;
        logic [DW-1:0] d;
        d = DW'($urandom);
        k = cyc;
        for (int i = 0; i < n_reads; i++) serve(0, 1'b0, a, d, k + 1, k);
        req0 = 1'b1; we0 = 1'b0; addr0 = a; wdata0 = d;
        seen = 0;
        for (int i = 0; i < 80 && seen < n_reads; i++) begin
            @(posedge clk); #1;
            if (ack0) seen++;
        end
        req0 = 1'b0;
        check("hold_reads_count", 64'(seen), 64'(n_reads));
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < 256; i++) begin
            tb_mem[i] = '0;
            ref_mem[i] = '0;
        end
        last_rd[0] = '0;
        last_rd[1] = '0;
        rr_ptr = 1'b0;
        reset = 1'b1;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;

        // 1: reset then idle
        idle_cycles(2);
        reset = 1'b0;
        check("rst_outputs", 64'({ack0, ack1, MemWrite, MemRead, busy, gnt}), 64'd0);
        check("rst_mem_bus", 64'({mem_addr, mem_wdata}), 64'd0);
        check("rst_rdata", 64'({rdata0, rdata1}), 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("idle_quiet", 64'({busy, MemWrite, MemRead}), 64'd0);
        end

        // 2: port 0 write, 3: port 1 read back
        run_txn(1, 0, 1, 0, 8'h10, 8'h00, 16'h8888, 16'h0000);
        check("t2_rdata0_unchanged", 64'(rdata0), 64'h0000);
        idle_cycles(1);
        run_txn(0, 1, 0, 0, 8'h00, 8'h10, 16'h0000, 16'h0000);
        idle_cycles(2);
        check("t3_rdata1_held", 64'(rdata1), 64'h8888);

        // 4: simultaneous write/read collisions
        run_txn(1, 1, 1, 0, 8'h06, 8'h06, 16'h1111, 16'h0000);
        idle_cycles(1);
        run_txn(1, 1, 1, 0, 8'h06, 8'h06, 16'h2222, 16'h0000);
        idle_cycles(1);

        // 5: reset during ISSUE of a port 0 read
        run_txn(1, 0, 1, 0, 8'h08, 8'h00, 16'hA5A5, 16'h0000);
        run_txn(1, 0, 0, 0, 8'h08, 8'h00, 16'h0000, 16'h0000);
        idle_cycles(1);
        exp_mq.push_back({1'b0, 1'b0, 8'h08, 16'h0000});
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h08; wdata0 = 16'h0000;
        @(posedge clk); #1;
        check("t5_in_issue", 64'({busy, MemRead}), 64'd3);
        @(negedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("t5_abort_ctrl", 64'({busy, MemRead, MemWrite, ack0}), 64'd0);
        check("t5_abort_rdata0", 64'(rdata0), 64'h0000);
        req0 = 1'b0;
        reset = 1'b0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        rr_ptr = 1'b0;
        idle_cycles(6);

        // 6: port 0 holds req high through several reads
        hold_reads(8'h10, 3);
        idle_cycles(2);

        // randomized mix of single and colliding requests
        for (int n = 0; n < 40; n++) begin
            int mode;
            mode = int'($urandom_range(0, 2));
            run_txn(mode != 1, mode != 0, 1'($urandom), 1'($urandom),
                    AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
                    DW'($urandom), DW'($urandom));
            idle_cycles(int'($urandom_range(0, 2)));
        end

        idle_cycles(4);
        check("queues_empty", 64'(exp_q0.size() + exp_q1.size() + exp_mq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
